// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths, source indices and broadcast entry type for the CDB arbiter
`ifndef CDB_UTILS_DEFINES
`define CDB_UTILS_DEFINES
`define ROB_RANGE  3:0
`define DATA_RANGE 31:0
`define SRC_ALU    0
`define SRC_LSB    1
`define SRC_AUX    2
`endif

package cdb_arbiter_pkg;

    localparam int ROB_W = 4;
    localparam int SRC_W = 2;

    // One buffered result; the ROB tag is called "tag" because "alias" is reserved.
    typedef struct packed {
        logic [`ROB_RANGE]  tag;
        logic [`DATA_RANGE] result;
        logic               jump;
        logic [`DATA_RANGE] pc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - per-source result requests and registered CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int NSRC = 3
);
    import cdb_arbiter_pkg::*;

    logic [NSRC-1:0]       req_valid;
    logic [NSRC-1:0]       req_ready;
    logic [NSRC*ROB_W-1:0] req_alias;
    logic [NSRC*32-1:0]    req_result;
    logic [NSRC-1:0]       req_jump;
    logic [NSRC*32-1:0]    req_pc;

    logic                  cdb_valid;
    logic [`ROB_RANGE]     cdb_alias;
    logic [`DATA_RANGE]    cdb_result;
    logic                  cdb_jump;
    logic [`DATA_RANGE]    cdb_pc;
    logic [SRC_W-1:0]      cdb_src;

    // Result producers and CDB listeners
    modport master (
        output req_valid, req_alias, req_result, req_jump, req_pc,
        input  req_ready, cdb_valid, cdb_alias, cdb_result, cdb_jump, cdb_pc, cdb_src
    );

    // The arbiter
    modport slave (
        input  req_valid, req_alias, req_result, req_jump, req_pc,
        output req_ready, cdb_valid, cdb_alias, cdb_result, cdb_jump, cdb_pc, cdb_src
    );

endinterface

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - small per-source result buffer with registered occupancy and flush
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  cdb_entry_t    wdata,
    output logic [CW-1:0] count,
    output cdb_entry_t    head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cdb_entry_t    mem_q [DEPTH];
    cdb_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work too
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next state: nothing moves while disabled; flush beats push/pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (en) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) begin
                    mem_d[wr_ptr_q] = wdata;
                    wr_ptr_d        = ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter merging per-source results onto the registered CDB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NSRC       = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rollback,
    cdb_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic             enable;
    logic [NSRC-1:0]  ready;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [NSRC-1:0]  nonempty;
    logic [CW-1:0]    count [NSRC];
    cdb_entry_t       wdata [NSRC];
    cdb_entry_t       head  [NSRC];

    logic             grant_valid;
    logic [IW-1:0]    grant_idx;

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    cdb_entry_t       cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

    assign enable = rdy && !rollback;

    // Accept depends only on registered occupancy; tag-zero results are acked but never stored
    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        for (int i = 0; i < NSRC; i++) begin
            wdata[i].tag    = bus.req_alias[i*ROB_W +: ROB_W];
            wdata[i].result = bus.req_result[i*32 +: 32];
            wdata[i].jump   = bus.req_jump[i];
            wdata[i].pc     = bus.req_pc[i*32 +: 32];
            nonempty[i]     = (count[i] != '0);
            ready[i]        = enable && !rst && (count[i] < CW'(FIFO_DEPTH));
            push[i]         = bus.req_valid[i] && ready[i] && (wdata[i].tag != '0);
        end
    end

    // First non-empty source scanning upward from rr_ptr, wrapping at NSRC
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NSRC) begin
                idx = idx - NSRC;
            end
            if (!grant_valid && nonempty[IW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    // Pop the granted head only in cycles that actually advance state
    always_comb begin
        pop = '0;
        for (int i = 0; i < NSRC; i++) begin
            pop[i] = enable && grant_valid && (grant_idx == IW'(i));
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        cdb_fifo #(
            .DEPTH (FIFO_DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .en    (rdy),
            .flush (rollback),
            .push  (push[i]),
            .pop   (pop[i]),
            .wdata (wdata[i]),
            .count (count[i]),
            .head  (head[i])
        );
    end

    // Broadcast register and round-robin pointer: rollback clears, a grant loads, idle drops valid
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_d       = cdb_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (rdy) begin
            if (rollback) begin
                cdb_valid_d = 1'b0;
                rr_ptr_d    = '0;
            end else if (grant_valid) begin
                cdb_valid_d = 1'b1;
                cdb_d       = head[grant_idx];
                cdb_src_d   = SRC_W'(grant_idx);
                rr_ptr_d    = (grant_idx == IW'(NSRC - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    // Output and pointer registers; reset wins regardless of rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            cdb_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
            cdb_src_q   <= cdb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_alias  = cdb_q.tag;
    assign bus.cdb_result = cdb_q.result;
    assign bus.cdb_jump   = cdb_q.jump;
    assign bus.cdb_pc     = cdb_q.pc;
    assign bus.cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    cdb_arbiter_if #(.NSRC(3)) bus ();

    cdb_arbiter #(
        .NSRC       (3),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    cdb_entry_t q0[$];
    cdb_entry_t q1[$];
    cdb_entry_t q2[$];

    logic fresh = 1'b0;

    always @(posedge clk) fresh <= rdy && !rst;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_entry_t mk(input logic [3:0] t, input logic [31:0] r);
        cdb_entry_t e;
        e.tag    = t;
        e.result = r;
        e.jump   = t[0];
        e.pc     = {24'h000100, t, 4'h0};
        return e;
    endfunction

    task automatic drive(input int s, input cdb_entry_t e);
        bus.req_valid[s]               = 1'b1;
        bus.req_alias[s*ROB_W +: ROB_W] = e.tag;
        bus.req_result[s*32 +: 32]     = e.result;
        bus.req_jump[s]                = e.jump;
        bus.req_pc[s*32 +: 32]         = e.pc;
    endtask

    task automatic idle();
        bus.req_valid = '0;
    endtask

    // Record every handshake that should eventually be broadcast
    task automatic accept();
        cdb_entry_t e;
        #1;
        for (int s = 0; s < 3; s++) begin
            e.tag    = bus.req_alias[s*ROB_W +: ROB_W];
            e.result = bus.req_result[s*32 +: 32];
            e.jump   = bus.req_jump[s];
            e.pc     = bus.req_pc[s*32 +: 32];
            if (bus.req_valid[s] && bus.req_ready[s] && e.tag != 4'd0) begin
                case (s)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic check_cdb(input string tag, input logic v, input logic [3:0] a, input logic [1:0] s);
        check({tag, "_valid"}, bus.cdb_valid, v);
        if (v) begin
            check({tag, "_alias"}, bus.cdb_alias, a);
            check({tag, "_src"}, bus.cdb_src, s);
        end
    endtask

    // Scoreboard: each fresh broadcast must match the oldest pending entry of its source
    always @(negedge clk) begin
        cdb_entry_t e;
        cdb_entry_t got;
        logic       has;
        if (fresh && bus.cdb_valid) begin
            got.tag    = bus.cdb_alias;
            got.result = bus.cdb_result;
            got.jump   = bus.cdb_jump;
            got.pc     = bus.cdb_pc;
            has        = 1'b0;
            e          = '0;
            case (bus.cdb_src)
                2'd0: if (q0.size() != 0) begin e = q0.pop_front(); has = 1'b1; end
                2'd1: if (q1.size() != 0) begin e = q1.pop_front(); has = 1'b1; end
                2'd2: if (q2.size() != 0) begin e = q2.pop_front(); has = 1'b1; end
                default: has = 1'b0;
            endcase
            check("sb_expected_pending", has, 1'b1);
            if (has) check("sb_entry", 96'(got), 96'(e));
        end
    end

    initial begin
        int a_idx;
        int l_idx;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.req_valid = '0; bus.req_alias = '0; bus.req_result = '0;
        bus.req_jump = '0; bus.req_pc = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", bus.req_ready, 3'b000);
        check("rst_cdb_valid", bus.cdb_valid, 1'b0);
        check("rst_cdb_alias", bus.cdb_alias, 4'd0);
        check("rst_cdb_result", bus.cdb_result, 32'd0);
        check("rst_cdb_jump", bus.cdb_jump, 1'b0);
        check("rst_cdb_pc", bus.cdb_pc, 32'd0);
        check("rst_cdb_src", bus.cdb_src, 2'd0);
        rst = 1'b0;
        #1 check("post_rst_ready", bus.req_ready, 3'b111);

        // Contention from rr_ptr=0: 1, 2, 3 on consecutive cycles
        drive(0, mk(4'd1, 32'hA000_0001)); drive(1, mk(4'd2, 32'hA000_0002)); drive(2, mk(4'd3, 32'hA000_0003));
        accept();
        @(negedge clk); idle();
        check_cdb("cont_lat", 1'b0, 4'd0, 2'd0);
        @(negedge clk); check_cdb("cont_1", 1'b1, 4'd1, 2'd0);
        @(negedge clk); check_cdb("cont_2", 1'b1, 4'd2, 2'd1);
        @(negedge clk); check_cdb("cont_3", 1'b1, 4'd3, 2'd2);
        @(negedge clk); check_cdb("cont_end", 1'b0, 4'd0, 2'd0);

        // rr_ptr back at 0: LSB must win over AUX
        drive(2, mk(4'd4, 32'hA000_0004)); drive(1, mk(4'd5, 32'hA000_0005));
        accept();
        @(negedge clk); idle();
        @(negedge clk); check_cdb("rr_wrap_a", 1'b1, 4'd5, 2'd1);
        @(negedge clk); check_cdb("rr_wrap_b", 1'b1, 4'd4, 2'd2);
        @(negedge clk); check_cdb("rr_wrap_end", 1'b0, 4'd0, 2'd0);

        // Single ALU request: visible one edge after acceptance, for one cycle
        drive(0, mk(4'd5, 32'h0000_1234));
        accept();
        @(negedge clk); idle();
        check_cdb("single_lat", 1'b0, 4'd0, 2'd0);
        @(negedge clk); check_cdb("single", 1'b1, 4'd5, 2'd0);
        check("single_result", bus.cdb_result, 32'h0000_1234);
        @(negedge clk); check_cdb("single_once", 1'b0, 4'd0, 2'd0);

        // Backpressure: ALU always valid, LSB sends 3 back-to-back (rr_ptr=1 here)
        a_idx = 0; l_idx = 0;
        for (int n = 0; n < 6; n++) begin
            drive(0, mk(4'(8 + a_idx), 32'hA1A1_0000 + 32'(a_idx)));
            if (l_idx < 3) drive(1, mk(4'(1 + l_idx), 32'hB0B0_0000 + 32'(l_idx)));
            else bus.req_valid[1] = 1'b0;
            accept();
            if (n == 2) check("bp_alu_full_ready", bus.req_ready[0], 1'b0);
            if (n == 3) check("bp_lsb_full_ready", bus.req_ready[1], 1'b0);
            if (bus.req_ready[0]) a_idx++;
            if (l_idx < 3 && bus.req_ready[1]) l_idx++;
            @(negedge clk);
        end
        idle();
        check("bp_lsb_sent", 32'(l_idx), 32'd3);
        repeat (8) @(negedge clk);
        check("bp_drained_q0", 32'(q0.size()), 32'd0);
        check("bp_drained_q1", 32'(q1.size()), 32'd0);

        // Rollback: clear rr_ptr, buffer two entries behind a live broadcast, then flush
        rollback = 1'b1;
        @(negedge clk); rollback = 1'b0;
        drive(0, mk(4'd9, 32'h9999_0009)); drive(1, mk(4'd10, 32'h9999_000A)); drive(2, mk(4'd11, 32'h9999_000B));
        q0.push_back(mk(4'd9, 32'h9999_0009));
        @(negedge clk); idle();
        @(negedge clk); check_cdb("rb_pre", 1'b1, 4'd9, 2'd0);
        rollback = 1'b1;
        drive(2, mk(4'd12, 32'h9999_000C));
        #1 check("rb_ready", bus.req_ready, 3'b000);
        @(negedge clk); rollback = 1'b0; idle();
        check_cdb("rb_clear", 1'b0, 4'd0, 2'd0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); check_cdb("rb_quiet", 1'b0, 4'd0, 2'd0);
        end
        drive(0, mk(4'd1, 32'hC000_0001)); drive(1, mk(4'd2, 32'hC000_0002)); drive(2, mk(4'd3, 32'hC000_0003));
        accept();
        @(negedge clk); idle();
        @(negedge clk); check_cdb("rb_rr_1", 1'b1, 4'd1, 2'd0);
        @(negedge clk); check_cdb("rb_rr_2", 1'b1, 4'd2, 2'd1);
        @(negedge clk); check_cdb("rb_rr_3", 1'b1, 4'd3, 2'd2);

        // Stall: broadcast of alias 7 held for 4 cycles while rdy=0
        drive(0, mk(4'd7, 32'h7777_0007));
        accept();
        @(negedge clk); idle();
        drive(1, mk(4'd13, 32'h7777_000D));
        accept();
        @(negedge clk); idle();
        check_cdb("stall_pre", 1'b1, 4'd7, 2'd0);
        rdy = 1'b0;
        drive(0, mk(4'd14, 32'h7777_000E));
        accept();
        check("stall_ready0", bus.req_ready, 3'b000);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_cdb("stall_hold", 1'b1, 4'd7, 2'd0);
            check("stall_hold_result", bus.cdb_result, 32'h7777_0007);
            check("stall_ready", bus.req_ready, 3'b000);
        end
        idle(); rdy = 1'b1;
        @(negedge clk); check_cdb("stall_resume", 1'b1, 4'd13, 2'd1);
        @(negedge clk); check_cdb("stall_end", 1'b0, 4'd0, 2'd0);

        // Tag zero: acknowledged, never broadcast
        drive(0, mk(4'd0, 32'hDEAD_0000));
        accept();
        check("tag0_ready", bus.req_ready[0], 1'b1);
        @(negedge clk); idle();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk); check_cdb("tag0_quiet", 1'b0, 4'd0, 2'd0);
        end

        // Reset with entries buffered: all lost, no accept during reset
        drive(0, mk(4'd1, 32'hE000_0001)); drive(1, mk(4'd2, 32'hE000_0002)); drive(2, mk(4'd3, 32'hE000_0003));
        @(negedge clk); idle();
        rst = 1'b1;
        #1 check("rstmid_ready", bus.req_ready, 3'b000);
        @(negedge clk); rst = 1'b0;
        check_cdb("rstmid_clear", 1'b0, 4'd0, 2'd0);
        check("rstmid_alias", bus.cdb_alias, 4'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk); check_cdb("rstmid_quiet", 1'b0, 4'd0, 2'd0);
        end

        check("end_q0_empty", 32'(q0.size()), 32'd0);
        check("end_q1_empty", 32'(q1.size()), 32'd0);
        check("end_q2_empty", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NSRC, default 3, giving the number of result sources (0=ALU, 1=LSB, 2=spare unit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, giving the number of entries in each per-source buffer.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have port rdy (in, 1): global clock enable; when low, no state changes.
REQ-005 SHALL have port rollback (in, 1): misprediction flush from the ROB.
REQ-006 SHALL have port req_valid (in, NSRC): per-source result valid.
REQ-007 SHALL have port req_ready (out, NSRC): per-source accept.
REQ-008 SHALL have port req_alias (in, NSRC*ROB width, `ROB_RANGE slices): ROB tag per source.
REQ-009 SHALL have port req_result (in, NSRC*32): result per source.
REQ-010 SHALL have port req_jump (in, NSRC): branch taken flag per source.
REQ-011 SHALL have port req_pc (in, NSRC*32): resolved target PC per source.
REQ-012 SHALL have ports cdb_valid (out, 1), cdb_alias (out, `ROB_RANGE), cdb_result (out, 32), cdb_jump (out, 1) and cdb_pc (out, 32): the registered broadcast to the ROB, RS and LSB.
REQ-013 SHALL have port cdb_src (out, 2): index of the source whose entry is being broadcast.

Function
REQ-014 SHALL give each source a FIFO_DEPTH-entry FIFO holding {alias, result, jump, pc}, with a registered occupancy count.
REQ-015 SHALL drive req_ready[i] = rdy && !rollback && count[i] < FIFO_DEPTH; this is combinational from registers only and never depends on req_valid.
REQ-016 SHALL write an entry into FIFO i at the edge where req_valid[i] && req_ready[i] is true.
REQ-017 SHALL accept but discard a handshake whose alias is 0 (tag 0 means "no dependency"); no FIFO write occurs.
REQ-018 SHALL, each enabled cycle, grant exactly one non-empty FIFO, chosen round-robin starting from pointer rr_ptr.
REQ-019 SHALL set rr_ptr to (granted+1) mod NSRC after each grant; rr_ptr is unchanged when no grant occurs.
REQ-020 SHALL, at the edge ending a grant cycle, load cdb_* from the head of the granted FIFO, set cdb_valid=1 and pop that entry.
REQ-021 SHALL set cdb_valid=0 at the edge ending a cycle in which all FIFOs are empty.
REQ-022 SHALL broadcast an entry no earlier than one cycle after the acceptance edge: a request accepted at edge E into an empty system appears on cdb_* from edge E+1, for exactly one cycle.
REQ-023 SHALL, when one source pushes and pops in the same cycle, leave its count unchanged and keep the data order FIFO.
REQ-024 SHALL ensure no FIFO entry waits more than NSRC*FIFO_DEPTH grant cycles while rdy=1 (starvation bound).
REQ-025 SHALL, on rollback=1 with rdy=1, at the next edge: empty all FIFOs, clear cdb_valid, set rr_ptr=0, and drop any request presented in that cycle.
REQ-026 SHALL, while rdy=0, hold all registers including cdb_*, and keep req_ready=0.
REQ-027 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, on rst=1 at an edge, set cdb_valid=0, cdb_alias=0, cdb_result=0, cdb_jump=0, cdb_pc=0, cdb_src=0, rr_ptr=0, and all counts and pointers to 0, regardless of rdy.
REQ-029 SHALL give rst priority over rollback, and rollback priority over normal operation.
REQ-030 SHALL, when rst is asserted mid-transfer, lose all buffered entries; req_ready is 0 during the rst cycle.

Structure
REQ-031 SHALL take `ROB_RANGE, `DATA_RANGE and the source-index defines (`SRC_ALU=0, `SRC_LSB=1, `SRC_AUX=2) from utils.v.
REQ-032 SHALL implement the per-source buffer as one sub-module, cdb_fifo (push, pop, flush, count, head data), instantiated NSRC times.
REQ-033 SHALL keep the round-robin select and cdb_* output registers in cdb_arbiter itself.

Verification
REQ-034 Single request: ALU valid, alias 5, result 0x1234 at edge 10 -> cdb_valid=1, alias 5, result 0x1234, cdb_src=0 from edge 11 for one cycle.
REQ-035 Contention: all three sources push, aliases 1/2/3, same edge -> broadcasts alias 1, 2, 3 on consecutive cycles; rr_ptr returns to 0.
REQ-036 Backpressure: LSB pushes 3 back-to-back entries while the ALU saturates -> req_ready[1]=0 when count=2, no entry lost, order preserved.
REQ-037 Rollback: 2 entries buffered, rollback pulse -> next cycle cdb_valid=0, all counts 0; a request in the rollback cycle never broadcasts.
REQ-038 Stall: rdy=0 for 4 cycles with cdb_valid=1, alias 7 -> cdb_* held, req_ready=0, resumes normally when rdy=1.
REQ-039 Tag zero: request with alias 0 -> req_ready=1, no broadcast ever produced.
